// File: rtl/riscv_imm_decode_stage_if.sv
// Handshake bundle for the immediate-decode stage: upstream instruction offer and
// downstream decoded-entry presentation. The stage sits on the slave side.
interface riscv_imm_decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );
endinterface

// File: rtl/riscv_imm_decode_stage.sv
// RISC-V immediate decoder with a registered 2-entry skid buffer (main + skid).
// Decode is combinational on the offered word; results travel with the tag.
module riscv_imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  riscv_imm_decode_stage_if.slave bus
);

  localparam bit Rv64 = (XLEN == 64);

  localparam logic [2:0] TypeNone  = 3'd0;
  localparam logic [2:0] TypeI     = 3'd1;
  localparam logic [2:0] TypeS     = 3'd2;
  localparam logic [2:0] TypeB     = 3'd3;
  localparam logic [2:0] TypeU     = 3'd4;
  localparam logic [2:0] TypeJ     = 3'd5;
  localparam logic [2:0] TypeShamt = 3'd6;
  localparam logic [2:0] TypeZimm  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic [XLEN-1:0]   dec_imm;
  logic [2:0]        dec_type;
  logic              dec_illegal;
  entry_t            new_entry;

  assign instr   = bus.in_instr;
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
  assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u32 = {instr[31:12], 12'b0};
  assign imm_j32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // Signed 32-bit casts to XLEN sign-extend for the RV64 build.
  always_comb begin
    dec_imm     = '0;
    dec_type    = TypeNone;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0001111, 7'b1100111: begin
        dec_type = TypeI;
        dec_imm  = XLEN'(imm_i32);
      end
      7'b0100011: begin
        dec_type = TypeS;
        dec_imm  = XLEN'(imm_s32);
      end
      7'b1100011: begin
        dec_type = TypeB;
        dec_imm  = XLEN'(imm_b32);
      end
      7'b0110111, 7'b0010111: begin
        dec_type = TypeU;
        dec_imm  = XLEN'(imm_u32);
      end
      7'b1101111: begin
        dec_type = TypeJ;
        dec_imm  = XLEN'(imm_j32);
      end
      7'b0110011: ;
      7'b0010011: begin
        if (funct3[1:0] == 2'b01) begin
          dec_type = TypeShamt;
          if (!Rv64 && instr[25]) dec_illegal = 1'b1;
          else dec_imm = Rv64 ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          dec_type = TypeI;
          dec_imm  = XLEN'(imm_i32);
        end
      end
      7'b0011011: begin
        if (!Rv64) begin
          dec_illegal = 1'b1;
        end else if (funct3[1:0] == 2'b01) begin
          dec_type = TypeShamt;
          if (instr[25]) dec_illegal = 1'b1;
          else dec_imm = XLEN'(instr[24:20]);
        end else begin
          dec_type = TypeI;
          dec_imm  = XLEN'(imm_i32);
        end
      end
      7'b0111011: begin
        if (!Rv64) dec_illegal = 1'b1;
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_type = TypeZimm;
          dec_imm  = XLEN'(instr[19:15]);
        end else begin
          dec_type = TypeI;
          dec_imm  = XLEN'(imm_i32);
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_type = TypeNone;
      dec_imm  = '0;
    end
  end

  assign new_entry = '{imm: dec_imm, typ: dec_type, illegal: dec_illegal, tag: bus.in_tag};

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q;
  logic   accept, retire;

  assign accept = bus.in_valid & in_ready_q;
  assign retire = main_v_q & bus.out_ready;

  // in_ready_q mirrors an empty skid slot, so accept never coincides with skid_v_q.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (retire) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = new_entry;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      if (main_v_q) begin
        skid_d   = new_entry;
        skid_v_d = 1'b1;
      end else begin
        main_d   = new_entry;
        main_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= ~skid_v_d;
      main_q     <= main_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_v_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_type    = main_q.typ;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_tag     = main_q.tag;

endmodule
